// File: rtl/buffer_escrita_mem.sv
// buffer_escrita_mem: store buffer between the memory stage and the data RAM
// write port. Stores are queued in a small FIFO and drained one at a time over
// a we/ready handshake. Loads that hit any queued store (including the one
// currently being written) are flagged so the pipeline can stall.
module buffer_escrita_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      escrever_mem,
    input  logic [ADDR_WIDTH-1:0]     endereco_escrita,
    input  logic [DATA_WIDTH-1:0]     dado_escrita,
    output logic                      buffer_cheio,
    output logic                      buffer_vazio,
    output logic [$clog2(DEPTH):0]    ocupacao,
    input  logic                      ler_mem,
    input  logic [ADDR_WIDTH-1:0]     endereco_leitura,
    output logic                      conflito_leitura,
    output logic                      ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_endereco,
    output logic [DATA_WIDTH-1:0]     ram_dado,
    input  logic                      ram_pronto
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        OCIOSO     = 1'b0,
        ESCREVENDO = 1'b1
    } estado_t;

    estado_t               r_estado;
    logic [ADDR_WIDTH-1:0] r_end  [DEPTH];
    logic [DATA_WIDTH-1:0] r_dado [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_endereco;
    logic [DATA_WIDTH-1:0] r_ram_dado;

    logic                  w_cheio;
    logic                  w_push;
    logic                  w_pop;
    logic [PW-1:0]         w_rd_ptr_inc;
    logic                  w_restam;
    logic [ADDR_WIDTH-1:0] w_prox_end;
    logic [DATA_WIDTH-1:0] w_prox_dado;
    logic                  w_acerto;

    // Handshake decode and selection of the head that follows a pop; when only
    // the popping entry is stored, a same-edge push becomes the next head.
    always_comb begin
        w_cheio      = (r_count == CW'(DEPTH));
        w_push       = escrever_mem && !w_cheio;
        w_pop        = (r_estado == ESCREVENDO) && ram_pronto;
        w_rd_ptr_inc = r_rd_ptr + PW'(1);
        w_restam     = (r_count > CW'(1)) || w_push;
        if (r_count > CW'(1)) begin
            w_prox_end  = r_end[w_rd_ptr_inc];
            w_prox_dado = r_dado[w_rd_ptr_inc];
        end else begin
            w_prox_end  = endereco_escrita;
            w_prox_dado = dado_escrita;
        end
    end

    // Address match of the load against every stored entry, head included.
    always_comb begin
        w_acerto = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (r_end[PW'(r_rd_ptr + PW'(i))] == endereco_leitura)) begin
                w_acerto = 1'b1;
            end else begin
                w_acerto = w_acerto;
            end
        end
    end

    // FIFO storage, pointers, occupancy and the drain FSM with its RAM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_end[i]  <= '0;
                r_dado[i] <= '0;
            end
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_estado       <= OCIOSO;
            r_ram_we       <= 1'b0;
            r_ram_endereco <= '0;
            r_ram_dado     <= '0;
        end else begin
            if (w_push) begin
                r_end[r_wr_ptr]  <= endereco_escrita;
                r_dado[r_wr_ptr] <= dado_escrita;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end

            case (r_estado)
                OCIOSO: begin
                    if (r_count != CW'(0)) begin
                        r_ram_endereco <= r_end[r_rd_ptr];
                        r_ram_dado     <= r_dado[r_rd_ptr];
                        r_ram_we       <= 1'b1;
                        r_estado       <= ESCREVENDO;
                    end else begin
                        r_ram_we       <= 1'b0;
                    end
                end
                ESCREVENDO: begin
                    if (ram_pronto) begin
                        r_rd_ptr <= w_rd_ptr_inc;
                        if (w_restam) begin
                            r_ram_endereco <= w_prox_end;
                            r_ram_dado     <= w_prox_dado;
                            r_ram_we       <= 1'b1;
                        end else begin
                            r_ram_we       <= 1'b0;
                            r_estado       <= OCIOSO;
                        end
                    end else begin
                        r_ram_we <= 1'b1;
                    end
                end
                default: begin
                    r_ram_we <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign buffer_cheio     = w_cheio;
    assign buffer_vazio     = (r_count == CW'(0));
    assign ocupacao         = r_count;
    assign conflito_leitura = ler_mem && w_acerto;
    assign ram_we           = r_ram_we;
    assign ram_endereco     = r_ram_endereco;
    assign ram_dado         = r_ram_dado;

endmodule

// File: tb/tb_buffer_escrita_mem.sv
// Bench for buffer_escrita_mem: a queue-based model of the store buffer is
// checked against the DUT on every falling edge, with directed scenarios and
// hand-computed literal expectations at key points.
module tb_buffer_escrita_mem;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          escrever_mem;
    logic [AW-1:0] endereco_escrita;
    logic [DW-1:0] dado_escrita;
    logic          buffer_cheio;
    logic          buffer_vazio;
    logic [2:0]    ocupacao;
    logic          ler_mem;
    logic [AW-1:0] endereco_leitura;
    logic          conflito_leitura;
    logic          ram_we;
    logic [AW-1:0] ram_endereco;
    logic [DW-1:0] ram_dado;
    logic          ram_pronto;

    int n_cmp = 0;
    int n_bad = 0;

    buffer_escrita_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .escrever_mem(escrever_mem), .endereco_escrita(endereco_escrita),
        .dado_escrita(dado_escrita), .buffer_cheio(buffer_cheio),
        .buffer_vazio(buffer_vazio), .ocupacao(ocupacao),
        .ler_mem(ler_mem), .endereco_leitura(endereco_leitura),
        .conflito_leitura(conflito_leitura), .ram_we(ram_we),
        .ram_endereco(ram_endereco), .ram_dado(ram_dado),
        .ram_pronto(ram_pronto)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_we   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the queue holds every accepted store not yet committed; the RAM
    // port presents the queue head, starting one edge after the buffer became
    // non-empty and advancing immediately on each accepted write.
    always @(posedge clk or negedge rst_n) begin
        int   pre;
        logic push_ok;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            pre     = q.size();
            push_ok = escrever_mem && (pre < DEPTH);
            e.a     = endereco_escrita;
            e.d     = dado_escrita;
            if (m_we) begin
                if (ram_pronto) begin
                    void'(q.pop_front());
                    if (push_ok) q.push_back(e);
                    if (q.size() > 0) begin
                        m_addr = q[0].a;
                        m_data = q[0].d;
                    end else begin
                        m_we = 1'b0;
                    end
                end else if (push_ok) begin
                    q.push_back(e);
                end
            end else begin
                if (pre > 0) begin
                    m_we   = 1'b1;
                    m_addr = q[0].a;
                    m_data = q[0].d;
                end
                if (push_ok) q.push_back(e);
            end
        end
    end

    // Per-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        logic conf;
        conf = 1'b0;
        foreach (q[i]) if (q[i].a == endereco_leitura) conf = 1'b1;
        conf = conf && ler_mem;
        chk("ram_we", 64'(ram_we), 64'(m_we));
        if (m_we || !rst_n) begin
            chk("ram_endereco", 64'(ram_endereco), 64'(m_addr));
            chk("ram_dado", 64'(ram_dado), 64'(m_data));
        end
        chk("ocupacao", 64'(ocupacao), 64'(q.size()));
        chk("buffer_cheio", 64'(buffer_cheio), 64'(q.size() == DEPTH));
        chk("buffer_vazio", 64'(buffer_vazio), 64'(q.size() == 0));
        chk("conflito_leitura", 64'(conflito_leitura), 64'(conf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        escrever_mem     = 1'b1;
        endereco_escrita = a;
        dado_escrita     = d;
    endtask

    initial begin
        rst_n = 1'b0;
        escrever_mem = 1'b0; endereco_escrita = '0; dado_escrita = '0;
        ler_mem = 1'b0; endereco_leitura = '0; ram_pronto = 1'b0;
        tick(); tick();
        chk("reset_vazio", 64'(buffer_vazio), 64'd1);
        chk("reset_we", 64'(ram_we), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single store, RAM always ready
        ram_pronto = 1'b1;
        push(10'h010, 32'hDEADBEEF);
        tick();
        escrever_mem = 1'b0;
        chk("t1_ocup", 64'(ocupacao), 64'd1);
        chk("t1_we_before", 64'(ram_we), 64'd0);
        tick();
        chk("t1_we", 64'(ram_we), 64'd1);
        chk("t1_addr", 64'(ram_endereco), 64'h010);
        chk("t1_data", 64'(ram_dado), 64'hDEADBEEF);
        tick();
        chk("t1_we_after", 64'(ram_we), 64'd0);
        chk("t1_vazio", 64'(buffer_vazio), 64'd1);

        // Fill to full, fifth push ignored, RAM stalls keep outputs stable
        ram_pronto = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(AW'(i), 32'h1000 + 32'(i));
            tick();
        end
        push(10'h005, 32'h1005);
        tick();
        escrever_mem = 1'b0;
        chk("t2_ocup", 64'(ocupacao), 64'd4);
        chk("t2_cheio", 64'(buffer_cheio), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("t5_addr_stable", 64'(ram_endereco), 64'h001);
            chk("t5_data_stable", 64'(ram_dado), 64'h1001);
            tick();
        end
        ram_pronto = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("t2_drain_we", 64'(ram_we), 64'd1);
            chk("t2_drain_addr", 64'(ram_endereco), 64'(k));
            tick();
        end
        chk("t2_done_we", 64'(ram_we), 64'd0);
        chk("t2_done_vazio", 64'(buffer_vazio), 64'd1);

        // Load conflict against the head being written
        ram_pronto = 1'b0;
        push(10'h020, 32'hCAFE0020);
        tick();
        escrever_mem = 1'b0;
        tick();
        ler_mem = 1'b1; endereco_leitura = 10'h020; #1;
        chk("t3_conf_hit", 64'(conflito_leitura), 64'd1);
        endereco_leitura = 10'h021; #1;
        chk("t3_conf_miss", 64'(conflito_leitura), 64'd0);
        endereco_leitura = 10'h020;
        ram_pronto = 1'b1;
        tick();
        ram_pronto = 1'b0;
        chk("t3_conf_clear", 64'(conflito_leitura), 64'd0);
        ler_mem = 1'b0;
        tick();

        // Steady push+pop at occupancy 2 across pointer wrap
        push(10'h100, $urandom);
        tick();
        push(10'h101, $urandom);
        tick();
        ram_pronto = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(AW'(10'h102 + k), $urandom);
            tick();
            chk("t4_ocup", 64'(ocupacao), 64'd2);
        end
        escrever_mem = 1'b0;
        tick(); tick(); tick();
        chk("t4_vazio", 64'(buffer_vazio), 64'd1);

        // Reset in the middle of a write with three entries pending
        ram_pronto = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(AW'(10'h200 + i), 32'h2000 + 32'(i));
            tick();
        end
        escrever_mem = 1'b0;
        chk("t6_we_pre", 64'(ram_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we_async", 64'(ram_we), 64'd0);
        chk("t6_ocup_async", 64'(ocupacao), 64'd0);
        tick();
        rst_n = 1'b1;
        ram_pronto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_no_stale", 64'(ram_we), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
